// File: rtl/systolic_skew_feeder.sv
// Skews one matrix row per beat into a diagonal wavefront for the MAC array edge.
// Per-lane valids, selectable skew direction, tile drain with out_last.
module systolic_skew_feeder #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAC_WIDTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_SIZE*MAC_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic                           skew_rev,
    output logic                           in_ready,
    output logic [DATA_SIZE*MAC_WIDTH-1:0] out_data,
    output logic [MAC_WIDTH-1:0]           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic [CNT_W-1:0]               row_count
);

    localparam int unsigned ROW_W = DATA_SIZE * MAC_WIDTH;
    localparam int unsigned DC_W  = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_n;
    logic                   dir_q, dir_n;
    logic [DC_W-1:0]        drain_cnt_q, drain_cnt_n;
    logic [CNT_W-1:0]       row_count_q, row_count_n;
    logic                   out_last_q, out_last_n;
    logic [ROW_W-1:0]       out_data_q, out_data_n;
    logic [MAC_WIDTH-1:0]   out_valid_q, out_valid_n;

    logic [DATA_SIZE-1:0]   stg_d_q [MAC_WIDTH][MAC_WIDTH];
    logic [DATA_SIZE-1:0]   stg_d_n [MAC_WIDTH][MAC_WIDTH];
    logic                   stg_v_q [MAC_WIDTH][MAC_WIDTH];
    logic                   stg_v_n [MAC_WIDTH][MAC_WIDTH];

    logic                   adv;
    logic                   accept;
    logic                   dir_eff;
    logic                   clear_chain;

    assign adv      = out_ready;
    assign in_ready = out_ready & reset & ((state_q == IDLE) | (state_q == FILL));
    assign accept   = in_valid & in_ready;
    // A tile's direction is taken live on its first accept, then held.
    assign dir_eff  = (state_q == IDLE) ? skew_rev : dir_q;

    // Tile FSM: next state, counters and out_last
    always_comb begin
        state_n     = state_q;
        dir_n       = dir_q;
        drain_cnt_n = drain_cnt_q;
        row_count_n = row_count_q;
        clear_chain = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_n       = skew_rev;
                    row_count_n = CNT_W'(1);
                    drain_cnt_n = '0;
                    state_n     = in_last ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (row_count_q != {CNT_W{1'b1}}) begin
                        row_count_n = row_count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        drain_cnt_n = '0;
                        state_n     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    if (drain_cnt_q == DC_W'(MAC_WIDTH - 1)) begin
                        state_n     = IDLE;
                        row_count_n = '0;
                        clear_chain = 1'b1;
                    end else begin
                        drain_cnt_n = drain_cnt_q + DC_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        out_last_n = (state_n == DRAIN) && (drain_cnt_n == DC_W'(MAC_WIDTH - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            drain_cnt_q <= '0;
            row_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            dir_q       <= dir_n;
            drain_cnt_q <= drain_cnt_n;
            row_count_q <= row_count_n;
            out_last_q  <= out_last_n;
        end
    end

    // Lane chains; the output register captures the tap the chain will hold after this edge.
    // Once a tile has drained everything left in the chains is already emitted, so it is
    // flushed to keep a direction change from replaying stale elements.
    always_comb begin
        out_data_n  = '0;
        out_valid_n = '0;
        for (int i = 0; i < int'(MAC_WIDTH); i++) begin
            stg_d_n[i][0] = accept ? in_data[i*DATA_SIZE +: DATA_SIZE] : '0;
            stg_v_n[i][0] = accept;
            for (int k = 1; k < int'(MAC_WIDTH); k++) begin
                stg_d_n[i][k] = stg_d_q[i][k-1];
                stg_v_n[i][k] = stg_v_q[i][k-1];
            end
            out_data_n[i*DATA_SIZE +: DATA_SIZE] =
                stg_d_n[i][dir_eff ? (int'(MAC_WIDTH) - 1 - i) : i];
            out_valid_n[i] = stg_v_n[i][dir_eff ? (int'(MAC_WIDTH) - 1 - i) : i];
            if (clear_chain) begin
                for (int k = 0; k < int'(MAC_WIDTH); k++) begin
                    stg_d_n[i][k] = '0;
                    stg_v_n[i][k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MAC_WIDTH); i++) begin
                for (int k = 0; k < int'(MAC_WIDTH); k++) begin
                    stg_d_q[i][k] <= '0;
                    stg_v_q[i][k] <= 1'b0;
                end
            end
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else if (adv) begin
            for (int i = 0; i < int'(MAC_WIDTH); i++) begin
                for (int k = 0; k < int'(MAC_WIDTH); k++) begin
                    stg_d_q[i][k] <= stg_d_n[i][k];
                    stg_v_q[i][k] <= stg_v_n[i][k];
                end
            end
            out_data_q  <= out_data_n;
            out_valid_q <= out_valid_n;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign row_count = row_count_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: 4-lane instance against a row-history model,
// plus a 1-lane instance with literal checks.
module tb_systolic_skew_feeder;

    localparam int MW     = 4;
    localparam int DEPTH  = 1024;
    localparam int RC_MAX = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, skew_rev = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_last, busy;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [1:0]  row_count;

    logic [7:0]  in1_data = '0;
    logic        in1_valid = 1'b0, in1_last = 1'b0, out1_ready = 1'b0;
    logic        in1_ready, out1_last, busy1;
    logic [7:0]  out1_data;
    logic [0:0]  out1_valid;
    logic [15:0] row1;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 clock = ~clock;

    systolic_skew_feeder #(.DATA_SIZE(8), .MAC_WIDTH(MW), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .skew_rev(skew_rev), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .row_count(row_count)
    );

    systolic_skew_feeder #(.DATA_SIZE(8), .MAC_WIDTH(1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .in_data(in1_data), .in_valid(in1_valid),
        .in_last(in1_last), .skew_rev(1'b0), .in_ready(in1_ready),
        .out_data(out1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_last(out1_last), .busy(busy1), .row_count(row1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of what entered the array on each advance, indexed by advance number.
    int          n = 0;
    int          base = 1;
    logic [31:0] fed_data [DEPTH];
    bit          fed_v    [DEPTH];
    bit          fed_last [DEPTH];
    bit          fed_dir  [DEPTH];
    bit          m_open = 1'b0;
    bit          m_dir = 1'b0;
    bit          m_acc;
    int          m_last_r = -1;
    int          m_rc = 0;
    int          m_idx;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            base     = n + 1;
            m_open   = 1'b0;
            m_last_r = -1;
            m_rc     = 0;
        end else if (out_ready) begin
            m_acc = in_valid && (m_last_r < 0);
            n = n + 1;
            m_idx = n % DEPTH;
            fed_v[m_idx]    = m_acc;
            fed_last[m_idx] = m_acc && in_last;
            fed_data[m_idx] = in_data;
            if (m_acc) begin
                if (!m_open) begin
                    m_dir  = skew_rev;
                    m_rc   = 1;
                    m_open = 1'b1;
                end else if (m_rc < RC_MAX) begin
                    m_rc++;
                end
                fed_dir[m_idx] = m_dir;
                if (in_last) begin
                    m_open   = 1'b0;
                    m_last_r = n;
                end
            end else if (m_last_r >= 0 && n == m_last_r + MW) begin
                m_rc     = 0;
                m_last_r = -1;
            end
        end
    end

    // Row r reaches lane i on advance r + delay(i) - 1.
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [31:0] ed;
            logic [3:0]  ev;
            logic        el;
            int          lo;
            int          dly;
            ed = '0;
            ev = '0;
            el = 1'b0;
            lo = (n - MW + 1 < base) ? base : n - MW + 1;
            for (int r = lo; r <= n; r++) begin
                if (fed_v[r % DEPTH]) begin
                    for (int i = 0; i < MW; i++) begin
                        dly = fed_dir[r % DEPTH] ? (MW - i) : (i + 1);
                        if (r + dly - 1 == n) begin
                            ed[i*8 +: 8] = fed_data[r % DEPTH][i*8 +: 8];
                            ev[i] = 1'b1;
                        end
                    end
                end
                if (fed_last[r % DEPTH] && r + MW - 1 == n) el = 1'b1;
            end
            check("out_data", out_data, ed);
            check("out_valid", out_valid, ev);
            check("out_last", out_last, el);
            check("busy", busy, m_open || m_last_r >= 0);
            check("row_count", row_count, m_rc);
            check("in_ready", in_ready, out_ready && reset && m_last_r < 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        step();
    endtask

    localparam logic [31:0] RA = 32'hA3A2A1A0;
    localparam logic [31:0] RB = 32'hB3B2B1B0;
    localparam logic [31:0] RC = 32'hC3C2C1C0;

    task automatic scen_fwd();
        skew_rev = 1'b0;
        drive(1'b1, RA, 1'b0);
        check("s1_lane0_A", out_data, 32'h000000A0);
        check("s1_valid1", out_valid, 4'b0001);
        drive(1'b1, RB, 1'b0);
        drive(1'b1, RC, 1'b1);
        check("s1_rowcnt_peak", row_count, 2'd3);
        check("s1_valid3", out_valid, 4'b0111);
        drive(1'b0, '0, 1'b0);
        check("s1_diag", out_data, 32'hA3B2C100);
        check("s1_ready_drain", in_ready, 1'b0);
        step();
        step();
        check("s1_last", out_last, 1'b1);
        check("s1_lane3_C", out_data, 32'hC3000000);
        step();
        check("s1_busy_done", busy, 1'b0);
        check("s1_rowcnt_clr", row_count, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        out_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_valid", out_valid, 4'b0000);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        check("lone_last_ignored", busy, 1'b0);

        scen_fwd();

        // Reverse skew: lane 3 leads, lane 0 trails
        skew_rev = 1'b1;
        drive(1'b1, RA, 1'b0);
        check("s2_lane3_A", out_data, 32'hA3000000);
        drive(1'b1, RB, 1'b0);
        drive(1'b1, RC, 1'b1);
        drive(1'b0, '0, 1'b0);
        step();
        step();
        check("s2_last", out_last, 1'b1);
        check("s2_lane0_C", out_data, 32'h000000C0);
        check("s2_valid", out_valid, 4'b0001);
        step();

        // Stall mid-fill with a row pending
        skew_rev = 1'b0;
        drive(1'b1, RA, 1'b0);
        drive(1'b1, RB, 1'b0);
        out_ready = 1'b0;
        drive(1'b1, RC, 1'b1);
        check("s3_stall_ready", in_ready, 1'b0);
        check("s3_frozen", out_data, 32'h0000A1B0);
        drive(1'b1, RC, 1'b1);
        drive(1'b1, RC, 1'b1);
        check("s3_frozen2", out_data, 32'h0000A1B0);
        out_ready = 1'b1;
        drive(1'b1, RC, 1'b1);
        drive(1'b0, '0, 1'b0);
        repeat (4) step();

        // Bubble between rows; direction flip mid-tile must be ignored
        drive(1'b1, RA, 1'b0);
        skew_rev = 1'b1;
        drive(1'b0, '0, 1'b0);
        drive(1'b1, RB, 1'b1);
        check("s4_bubble", out_valid, 4'b0101);
        skew_rev = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (4) step();

        // Single-row tile
        drive(1'b1, RA, 1'b1);
        drive(1'b0, '0, 1'b0);
        step();
        check("s5_no_last_yet", out_last, 1'b0);
        step();
        check("s5_last", out_last, 1'b1);
        check("s5_valid", out_valid, 4'b1000);
        step();
        check("s5_idle", busy, 1'b0);

        // Row count saturates with a narrow counter
        for (int k = 0; k < 5; k++) drive(1'b1, 32'h01010101 * (k + 1), k == 4);
        check("sat_rowcnt", row_count, 2'd3);
        drive(1'b0, '0, 1'b0);
        repeat (4) step();

        // Reset during drain, then a normal tile
        drive(1'b1, RA, 1'b0);
        drive(1'b1, RB, 1'b1);
        drive(1'b0, '0, 1'b0);
        reset = 1'b0;
        #1;
        check("s6_valid", out_valid, 4'b0000);
        check("s6_busy", busy, 1'b0);
        check("s6_last", out_last, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        scen_fwd();

        // One-lane instance: out_last the beat after accept, one-advance drain
        in1_data  = 8'h5A;
        in1_valid = 1'b1;
        in1_last  = 1'b1;
        step();
        in1_valid = 1'b0;
        in1_last  = 1'b0;
        check("w1_last", out1_last, 1'b1);
        check("w1_valid", out1_valid, 1'b1);
        check("w1_data", out1_data, 8'h5A);
        check("w1_busy", busy1, 1'b1);
        check("w1_ready", in1_ready, 1'b0);
        check("w1_rowcnt", row1, 16'd1);
        step();
        check("w1_last_off", out1_last, 1'b0);
        check("w1_idle", busy1, 1'b0);
        check("w1_valid_off", out1_valid, 1'b0);
        check("w1_ready_back", in1_ready, 1'b1);

        step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
